// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus initiator: START, 7-bit address + R/W, one data byte
// (write or read), ACK/NACK handling and STOP. Outputs are open-drain
// release levels (1 = released). Each bit slot is four quarters of CLK_DIV clocks.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rx_data,
    output logic       scl_out,
    output logic       sda_out,
    input  logic       sda_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_STOP
    } state_t;

    localparam logic [7:0] QLAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] quarter_q, quarter_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;

    logic       q_end;
    logic       slot_end;
    logic       sample;
    logic [7:0] addr_byte;
    logic [2:0] bit_idx;

    assign q_end     = (qcnt_q == QLAST);
    assign slot_end  = q_end && (quarter_q == 2'd3);
    // sda_in is taken on the last clock of Q2, in the middle of SCL high
    assign sample    = q_end && (quarter_q == 2'd2);
    assign addr_byte = {addr_q, rw_q};
    assign bit_idx   = 3'd7 - bit_q;

    // Next-state logic: quarter timer, bit counter, FSM transitions and captures
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q == S_IDLE) begin
            qcnt_d    = '0;
            quarter_d = '0;
            bit_d     = '0;
            if (start) begin
                addr_d    = addr;
                rw_d      = rw;
                tx_d      = tx_data;
                ack_err_d = 1'b0;
                state_d   = S_START;
            end
        end else begin
            qcnt_d = q_end ? 8'd0 : qcnt_q + 8'd1;
            if (q_end) begin
                quarter_d = quarter_q + 2'd1;
            end
        end

        case (state_q)
            S_START: begin
                if (slot_end) begin
                    bit_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_ADDR_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                // ack_err was cleared on accept, so here it reflects this slot only
                if (slot_end) begin
                    bit_d   = '0;
                    state_d = ack_err_q ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (sample && rw_q) begin
                    shift_d = {shift_q[6:0], sda_in};
                end
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_DATA_ACK;
                    end
                end
            end
            S_DATA_ACK: begin
                if (sample && !rw_q && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    if (rw_q) begin
                        rx_d = shift_q;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    // State register; reset abandons any transaction without a STOP
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            rx_q      <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Captured transaction fields and read shifter carry no reset
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        rw_q    <= rw_d;
        tx_q    <= tx_d;
        shift_q <= shift_d;
    end

    // Bus drive decoded from registered state only; SDA moves at Q0 starts
    always_comb begin
        scl_out = 1'b1;
        sda_out = 1'b1;
        case (state_q)
            S_START: begin
                sda_out = ~quarter_q[1];
            end
            S_ADDR: begin
                scl_out = quarter_q[1];
                sda_out = addr_byte[bit_idx];
            end
            S_ADDR_ACK: begin
                scl_out = quarter_q[1];
            end
            S_DATA: begin
                scl_out = quarter_q[1];
                sda_out = rw_q ? 1'b1 : tx_q[bit_idx];
            end
            S_DATA_ACK: begin
                scl_out = quarter_q[1];
            end
            S_STOP: begin
                scl_out = (quarter_q != 2'd0);
                sda_out = quarter_q[1];
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rx_data = rx_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with CLK_DIV=4 and a behavioural slave.
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] tx_data = '0;
    logic       busy, done, ack_err;
    logic [7:0] rx_data;
    logic       scl_out, sda_out;
    logic       sda_in;

    int pass_cnt = 0;
    int total_cnt = 0;

    // slave model configuration and observations
    logic       slv_ack_addr = 1'b1;
    logic       slv_ack_data = 1'b1;
    logic [7:0] slv_rd_byte = 8'h00;
    logic       slv_sda = 1'b1;
    logic       frame = 1'b0;
    int         edge_cnt = 0;
    logic [7:0] addr_sh = '0;
    logic [7:0] data_sh = '0;
    logic       ack18 = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         hi_chg = 0;

    assign sda_in = sda_out & slv_sda;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .rx_data (rx_data),
        .scl_out (scl_out),
        .sda_out (sda_out),
        .sda_in  (sda_in)
    );

    // Slave: START/STOP detection, bit counting on SCL rises, drive on SCL falls;
    // also counts master SDA changes while SCL stays high
    always @(negedge clk) begin
        scl_p <= scl_out;
        sda_p <= sda_out;
        if (scl_p === 1'b1 && scl_out === 1'b1 && sda_p !== sda_out)
            hi_chg <= hi_chg + 1;
        if (scl_p === 1'b1 && scl_out === 1'b1 && sda_p === 1'b1 && sda_out === 1'b0) begin
            frame    <= 1'b1;
            edge_cnt <= 0;
            slv_sda  <= 1'b1;
        end else if (scl_p === 1'b1 && scl_out === 1'b1 && sda_p === 1'b0 && sda_out === 1'b1) begin
            frame   <= 1'b0;
            slv_sda <= 1'b1;
        end else if (frame && scl_p === 1'b0 && scl_out === 1'b1) begin
            edge_cnt <= edge_cnt + 1;
            if (edge_cnt + 1 <= 8) addr_sh <= {addr_sh[6:0], sda_in};
            else if (edge_cnt + 1 >= 10 && edge_cnt + 1 <= 17) data_sh <= {data_sh[6:0], sda_in};
            else if (edge_cnt + 1 == 18) ack18 <= sda_out;
        end else if (frame && scl_p === 1'b1 && scl_out === 1'b0) begin
            if (edge_cnt == 8) slv_sda <= slv_ack_addr ? 1'b0 : 1'b1;
            else if (edge_cnt == 9) slv_sda <= (slv_ack_addr && addr_sh[0]) ? slv_rd_byte[7] : 1'b1;
            else if (edge_cnt >= 10 && edge_cnt <= 16) slv_sda <= addr_sh[0] ? slv_rd_byte[7 - (edge_cnt - 9)] : 1'b1;
            else if (edge_cnt == 17) slv_sda <= (!addr_sh[0] && !slv_ack_data) ? 1'b1 : (addr_sh[0] ? 1'b1 : 1'b0);
            else slv_sda <= 1'b1;
        end
    end

    // Accept one transaction and wait (bounded) for done; returns at the done cycle
    task automatic do_xfer(input logic [6:0] a, input logic r, input logic [7:0] d,
                           output int lat, output logic busy_a1, output logic aerr_a1,
                           output logic busy_dn);
        addr = a; rw = r; tx_data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_a1 = busy;
        aerr_a1 = ack_err;
        while (done !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        busy_dn = busy;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (scl_out !== 1'b1) $display("FAIL reset_scl: got %b want 1", scl_out); else pass_cnt++;
        total_cnt++; if (sda_out !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", ack_err); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx: got %h want 00", rx_data); else pass_cnt++;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int lat; logic b1, ae1, bd; int h0;
        slv_ack_addr = 1'b1; slv_ack_data = 1'b1;
        h0 = hi_chg;
        do_xfer(7'h3C, 1'b0, 8'h5A, lat, b1, ae1, bd);
        total_cnt++; if (lat !== 321) $display("FAIL wr_latency: got %0d want 321", lat); else pass_cnt++;
        total_cnt++; if (b1 !== 1'b1) $display("FAIL wr_busy_after_accept: got %b want 1", b1); else pass_cnt++;
        total_cnt++; if (bd !== 1'b0) $display("FAIL wr_busy_in_done: got %b want 0", bd); else pass_cnt++;
        total_cnt++; if (addr_sh !== 8'h78) $display("FAIL wr_addr_byte: got %h want 78", addr_sh); else pass_cnt++;
        total_cnt++; if (data_sh !== 8'h5A) $display("FAIL wr_data_byte: got %h want 5a", data_sh); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b0) $display("FAIL wr_ack_err: got %b want 0", ack_err); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL wr_rx: got %h want 00", rx_data); else pass_cnt++;
        total_cnt++; if (hi_chg - h0 !== 2) $display("FAIL wr_sda_while_scl_high: got %0d want 2", hi_chg - h0); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL wr_done_width: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_read();
        int lat; logic b1, ae1, bd; int h0;
        slv_ack_addr = 1'b1; slv_rd_byte = 8'hA5;
        h0 = hi_chg;
        do_xfer(7'h3C, 1'b1, 8'h00, lat, b1, ae1, bd);
        total_cnt++; if (lat !== 321) $display("FAIL rd_latency: got %0d want 321", lat); else pass_cnt++;
        total_cnt++; if (addr_sh !== 8'h79) $display("FAIL rd_addr_byte: got %h want 79", addr_sh); else pass_cnt++;
        total_cnt++; if (data_sh !== 8'hA5) $display("FAIL rd_bus_byte: got %h want a5", data_sh); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hA5) $display("FAIL rd_rx: got %h want a5", rx_data); else pass_cnt++;
        total_cnt++; if (ack18 !== 1'b1) $display("FAIL rd_master_nack: got %b want 1", ack18); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b0) $display("FAIL rd_ack_err: got %b want 0", ack_err); else pass_cnt++;
        total_cnt++; if (hi_chg - h0 !== 2) $display("FAIL rd_sda_while_scl_high: got %0d want 2", hi_chg - h0); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_addr_nack();
        int lat; logic b1, ae1, bd; int h0;
        slv_ack_addr = 1'b0;
        h0 = hi_chg;
        do_xfer(7'h50, 1'b0, 8'h50, lat, b1, ae1, bd);
        total_cnt++; if (lat !== 177) $display("FAIL an_latency: got %0d want 177", lat); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b1) $display("FAIL an_ack_err: got %b want 1", ack_err); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hA5) $display("FAIL an_rx_kept: got %h want a5", rx_data); else pass_cnt++;
        // 8 address rises + ACK rise + STOP rise, no data slots
        total_cnt++; if (edge_cnt !== 10) $display("FAIL an_scl_rises: got %0d want 10", edge_cnt); else pass_cnt++;
        total_cnt++; if (hi_chg - h0 !== 2) $display("FAIL an_sda_while_scl_high: got %0d want 2", hi_chg - h0); else pass_cnt++;
        slv_ack_addr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_data_nack();
        int lat; logic b1, ae1, bd;
        slv_ack_addr = 1'b1; slv_ack_data = 1'b0;
        do_xfer(7'h3C, 1'b0, 8'hC3, lat, b1, ae1, bd);
        total_cnt++; if (lat !== 321) $display("FAIL dn_latency: got %0d want 321", lat); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b1) $display("FAIL dn_ack_err: got %b want 1", ack_err); else pass_cnt++;
        total_cnt++; if (edge_cnt !== 19) $display("FAIL dn_scl_rises: got %0d want 19", edge_cnt); else pass_cnt++;
        slv_ack_data = 1'b1;
        @(negedge clk);
        do_xfer(7'h3C, 1'b0, 8'h11, lat, b1, ae1, bd);
        total_cnt++; if (ae1 !== 1'b0) $display("FAIL dn_ack_err_cleared: got %b want 0", ae1); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b0) $display("FAIL dn_next_ack_err: got %b want 0", ack_err); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat; int ndone; int dlat;
        ndone = 0; dlat = 0;
        slv_ack_addr = 1'b1; slv_ack_data = 1'b1;
        addr = 7'h3C; rw = 1'b0; tx_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (lat = 1; lat <= 420; lat++) begin
            if (done === 1'b1) begin ndone++; dlat = lat; end
            if (lat == 50) begin start = 1'b1; addr = 7'h11; rw = 1'b1; tx_data = 8'hFF; end
            if (lat == 51) start = 1'b0;
            @(negedge clk);
        end
        total_cnt++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d want 1", ndone); else pass_cnt++;
        total_cnt++; if (dlat !== 321) $display("FAIL ign_latency: got %0d want 321", dlat); else pass_cnt++;
        total_cnt++; if (addr_sh !== 8'h78) $display("FAIL ign_addr_byte: got %h want 78", addr_sh); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ign_idle_after: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; logic b1, ae1, bd;
        do_xfer(7'h3C, 1'b0, 8'h0F, lat, b1, ae1, bd);
        total_cnt++; if (lat !== 321) $display("FAIL b2b_first_latency: got %0d want 321", lat); else pass_cnt++;
        // accepted in the done cycle of the previous transaction
        do_xfer(7'h2A, 1'b0, 8'hF0, lat, b1, ae1, bd);
        total_cnt++; if (b1 !== 1'b1) $display("FAIL b2b_accept_in_done: got %b want 1", b1); else pass_cnt++;
        total_cnt++; if (lat !== 321) $display("FAIL b2b_second_latency: got %0d want 321", lat); else pass_cnt++;
        total_cnt++; if (addr_sh !== 8'h54) $display("FAIL b2b_addr_byte: got %h want 54", addr_sh); else pass_cnt++;
        total_cnt++; if (data_sh !== 8'hF0) $display("FAIL b2b_data_byte: got %h want f0", data_sh); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int h0;
        h0 = hi_chg;
        addr = 7'h3C; rw = 1'b0; tx_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // cycle accept+66: second clock of ADDR bit 3, Q0 (SCL low, bit value 1)
        repeat (65) @(negedge clk);
        total_cnt++; if (scl_out !== 1'b0) $display("FAIL rm_scl_before: got %b want 0", scl_out); else pass_cnt++;
        total_cnt++; if (sda_out !== 1'b1) $display("FAIL rm_sda_bit3: got %b want 1", sda_out); else pass_cnt++;
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        total_cnt++; if (scl_out !== 1'b1) $display("FAIL rm_scl: got %b want 1", scl_out); else pass_cnt++;
        total_cnt++; if (sda_out !== 1'b1) $display("FAIL rm_sda: got %b want 1", sda_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rm_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL rm_rx: got %h want 00", rx_data); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (hi_chg - h0 !== 1) $display("FAIL rm_sda_while_scl_high: got %0d want 1", hi_chg - h0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C bus initiator (master). Generates SCL, START, 7-bit address + R/W, one data byte (write or read), ACK/NACK handling and STOP.
- Drives the bus the slave-side receiver (SCL edge detection, SDA shifting) listens to. Used as the bench/host-side initiator and as the on-chip master for the slave path.
- Open-drain style: outputs are "release" levels (1 = released/high, 0 = pull low). No clock stretching, no arbitration.

Parameters:
- CLK_DIV, 10, system clocks per SCL quarter-period (SCL period = 4*CLK_DIV clocks); legal range 2..255

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous active-high reset (1 = reset)
- start  input  1  transaction request, sampled only when busy=0
- addr  input  7  slave address, captured on accept
- rw  input  1  0 = write tx_data, 1 = read one byte; captured on accept
- tx_data  input  8  write byte, captured on accept
- busy  output  1  high while a transaction is in progress
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  address or write-data NACK in last transaction
- rx_data  output  8  byte read from slave
- scl_out  output  1  SCL drive (1 = release)
- sda_out  output  1  SDA drive (1 = release)
- sda_in  input  1  resolved SDA bus level

Behaviour:
- Reset (n_rst=1 at a clk edge): next cycle scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, rx_data=0x00. State returns to IDLE and the bus is released. A reset mid-transaction generates no STOP.
- Accept: start=1 with busy=0 captures addr/rw/tx_data and clears ack_err. busy=1 from the next cycle. start while busy=1 is ignored, with no queueing.
- Quarter timer: counts 0..CLK_DIV-1. A quarter ends when the count reaches CLK_DIV-1. Each bit slot is quarters Q0..Q3.
- Bit slot:
  - SCL low in Q0/Q1, high in Q2/Q3.
  - SDA changes only at the start of Q0.
  - sda_in is sampled on the last clock of Q2.
- FSM, with quarter counts:
  - IDLE: scl/sda released.
  - START (4 quarters): Q0-Q1 SDA=1, SCL=1; Q2-Q3 SDA=0, SCL=1.
  - ADDR (8 slots): bits {addr,rw}, MSB first.
  - ADDR_ACK (1 slot): SDA released. Sample 0 = ACK, go to DATA. Sample 1 = NACK, set ack_err=1, go to STOP.
  - DATA (8 slots), MSB first:
    - Write: drives tx_data.
    - Read: SDA released; the sample shifts into an internal register.
  - DATA_ACK (1 slot):
    - Write: SDA released, sample; 1 sets ack_err.
    - Read: master drives NACK (SDA=1); rx_data is loaded from the shift register at the end of the slot.
  - STOP (4 quarters): Q0 SCL=0, SDA=0; Q1 SCL=1, SDA=0; Q2-Q3 SCL=1, SDA=1.
  - Then done.
- Completion: done=1 for exactly one cycle, in the cycle after the last STOP quarter ends. busy=0 in that same cycle.
  - Normal transaction: 80 quarters, so done at accept + 1 + 80*CLK_DIV cycles.
  - Address NACK: 44 quarters, so done at accept + 1 + 44*CLK_DIV cycles.
- rx_data changes only on a completed read with address ACK. ack_err holds until the next accept.
- A new start may be accepted in the same cycle done=1 (busy=0).
- SDA invariant: SDA never changes while SCL=1, except for the START and STOP edges.

Test Plan:
- CLK_DIV=4, write addr=0x3C tx_data=0x5A, slave model ACKs both -> SDA bits 0x78 then 0x5A, MSB first, at Q0; done at accept+321; ack_err=0; rx_data=0x00.
- CLK_DIV=4, read addr=0x3C, slave drives 0xA5 -> byte on bus 0x79; rx_data=0xA5 at done; master SDA=1 during DATA_ACK; ack_err=0.
- Address NACK (slave leaves SDA=1), write 0x50 -> ack_err=1; no data slots; STOP follows ADDR_ACK; done at accept+177; rx_data unchanged.
- Write data NACK -> ack_err=1; full 80-quarter frame; next accepted start clears ack_err to 0.
- start pulsed again at cycle 50 of a transaction -> ignored; exactly one done. A start in the done cycle is accepted (busy=1 next cycle).
- n_rst=1 during ADDR bit 3 -> next cycle scl_out=1, sda_out=1, busy=0, done=0; checker confirms no SDA change while SCL high over all tests except START/STOP.
